// File: rtl/noc_rr_switch_allocator.sv
// Wormhole switch allocator: one round-robin arbiter per output port, locking the
// winning input to that output until its tail flit transfers.
module noc_rr_switch_allocator #(
  parameter int N_PORT = 5,
  parameter int SEL_W  = 3,
  parameter int DEST_W = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_PORT-1:0]          req_valid,
  input  logic [N_PORT*DEST_W-1:0]   req_dest,
  input  logic [N_PORT-1:0]          req_tail,
  input  logic [N_PORT-1:0]          out_ready,
  output logic [N_PORT-1:0]          grant,
  output logic [N_PORT*SEL_W-1:0]    select,
  output logic [N_PORT-1:0]          out_busy
);

  // Handshake: a flit of input i moves in a cycle exactly when grant[i] is high;
  // grant already folds in req_valid[i] and out_ready of the locked output.

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [SEL_W-1:0] IN_NON   = SEL_W'(N_PORT);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_PORT - 1);
  localparam logic [SEL_W:0]   N_WIDE   = (SEL_W + 1)'(N_PORT);

  state_t             state_q [N_PORT];
  state_t             state_d [N_PORT];
  logic [SEL_W-1:0]   owner_q [N_PORT];
  logic [SEL_W-1:0]   owner_d [N_PORT];
  logic [SEL_W-1:0]   ptr_q   [N_PORT];
  logic [SEL_W-1:0]   ptr_d   [N_PORT];
  logic [N_PORT-1:0]  cand    [N_PORT];

  // cand[o][i]: input i currently asks for output o; out-of-range dests match nothing.
  always_comb begin
    for (int o = 0; o < N_PORT; o++) begin
      cand[o] = '0;
      for (int i = 0; i < N_PORT; i++) begin
        cand[o][i] = req_valid[i] && (req_dest[i*DEST_W +: DEST_W] == DEST_W'(o));
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int o = 0; o < N_PORT; o++) begin
      for (int i = 0; i < N_PORT; i++) begin
        if (state_q[o] == LOCKED && owner_q[o] == SEL_W'(i) && cand[o][i] && out_ready[o]) begin
          grant[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int o = 0; o < N_PORT; o++) begin
      out_busy[o] = (state_q[o] == LOCKED);
      select[o*SEL_W +: SEL_W] = (state_q[o] == LOCKED) ? owner_q[o] : IN_NON;
    end
  end

  // Next state: arbitrate only from IDLE, release only from LOCKED, so the two never share an edge.
  always_comb begin
    logic             found;
    logic [SEL_W:0]   sum;
    logic [SEL_W-1:0] idx;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int o = 0; o < N_PORT; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      found      = 1'b0;
      case (state_q[o])
        IDLE: begin
          for (int k = 0; k < N_PORT; k++) begin
            sum = {1'b0, ptr_q[o]} + (SEL_W + 1)'(k);
            if (sum >= N_WIDE) sum = sum - N_WIDE;
            idx = sum[SEL_W-1:0];
            if (!found && cand[o][idx]) begin
              found      = 1'b1;
              state_d[o] = LOCKED;
              owner_d[o] = idx;
              ptr_d[o]   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
          end
        end
        LOCKED: begin
          if (grant[owner_q[o]] && req_tail[owner_q[o]]) state_d[o] = IDLE;
        end
        default: state_d[o] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int o = 0; o < N_PORT; o++) begin
        state_q[o] <= IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < N_PORT; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
    end
  end

endmodule

// File: tb/tb_noc_rr_switch_allocator.sv
// Bench for noc_rr_switch_allocator: directed vector table, corner-case sequences,
// and random traffic against a lock/pointer model of the allocation rules.
module tb_noc_rr_switch_allocator;

  localparam int N  = 5;
  localparam int SW = 3;
  localparam int DW = 3;
  localparam logic [N*SW-1:0] SEL_IDLE = {5{3'd5}};

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_dest;
  logic [N-1:0]    req_tail;
  logic [N-1:0]    out_ready;
  logic [N-1:0]    grant;
  logic [N*SW-1:0] select;
  logic [N-1:0]    out_busy;

  noc_rr_switch_allocator #(.N_PORT(N), .SEL_W(SW), .DEST_W(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_dest(req_dest),
    .req_tail(req_tail), .out_ready(out_ready), .grant(grant),
    .select(select), .out_busy(out_busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // model state: which outputs are held, by whom, and each round-robin start point
  int m_lock  [N];
  int m_owner [N];
  int m_ptr   [N];

  logic [N-1:0]    g_s;
  logic [N*SW-1:0] sel_s;
  logic [N-1:0]    busy_s;

  typedef struct {
    logic [N-1:0]    valid;
    logic [N*DW-1:0] dest;
    logic [N-1:0]    tail;
    logic [N-1:0]    ready;
    logic [N-1:0]    g;
    logic [N*SW-1:0] sel;
    logic [N-1:0]    busy;
  } vec_t;

  vec_t tbl [11];

  logic [N-1:0] exp_q[$];
  logic [N-1:0] got_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] pk(int a0, int a1, int a2, int a3, int a4);
    return {3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  function automatic int dest_of(int i);
    return int'(req_dest[i*DW +: DW]);
  endfunction

  task automatic model_reset();
    for (int o = 0; o < N; o++) begin
      m_lock[o] = 0; m_owner[o] = 0; m_ptr[o] = 0;
    end
  endtask

  task automatic model_out(output logic [N-1:0] g, output logic [N*SW-1:0] s, output logic [N-1:0] b);
    int d;
    for (int o = 0; o < N; o++) begin
      b[o] = (m_lock[o] != 0);
      s[o*SW +: SW] = (m_lock[o] != 0) ? 3'(m_owner[o]) : 3'd5;
    end
    for (int i = 0; i < N; i++) begin
      d = dest_of(i);
      g[i] = req_valid[i] && d < N && m_lock[d] != 0 && m_owner[d] == i && out_ready[d];
    end
  endtask

  task automatic model_adv(input logic [N-1:0] g);
    int i;
    bit found;
    for (int o = 0; o < N; o++) begin
      if (m_lock[o] != 0) begin
        if (g[m_owner[o]] && req_tail[m_owner[o]]) m_lock[o] = 0;
      end else begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          i = (m_ptr[o] + k) % N;
          if (!found && req_valid[i] && dest_of(i) == o) begin
            found = 1;
            m_lock[o] = 1;
            m_owner[o] = i;
            m_ptr[o] = (i + 1) % N;
          end
        end
      end
    end
  endtask

  // Called just after a rising edge; checks outputs mid-cycle, then advances to the next edge.
  task automatic step();
    logic [N-1:0]    eg;
    logic [N*SW-1:0] es;
    logic [N-1:0]    eb;
    @(negedge clk);
    model_out(eg, es, eb);
    g_s = grant; sel_s = select; busy_s = out_busy;
    chk("model_grant", 32'(g_s), 32'(eg));
    chk("model_select", 32'(sel_s), 32'(es));
    chk("model_busy", 32'(busy_s), 32'(eb));
    model_adv(eg);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_select", 32'(select), 32'(SEL_IDLE));
    chk("rst_busy", 32'(out_busy), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N*DW-1:0] d,
                       input logic [N-1:0] t, input logic [N-1:0] r);
    req_valid = v; req_dest = d; req_tail = t; out_ready = r;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{5'b00010, pk(0,3,0,0,0), 5'b00000, 5'b11111, 5'b00000, SEL_IDLE,      5'b00000};
    tbl[1]  = '{5'b00010, pk(0,3,0,0,0), 5'b00000, 5'b11111, 5'b00010, pk(5,5,5,1,5), 5'b01000};
    tbl[2]  = '{5'b00010, pk(0,3,0,0,0), 5'b00010, 5'b11111, 5'b00010, pk(5,5,5,1,5), 5'b01000};
    tbl[3]  = '{5'b00000, pk(0,3,0,0,0), 5'b00000, 5'b11111, 5'b00000, SEL_IDLE,      5'b00000};
    tbl[4]  = '{5'b11111, pk(1,2,3,4,0), 5'b11111, 5'b11111, 5'b00000, SEL_IDLE,      5'b00000};
    tbl[5]  = '{5'b11111, pk(1,2,3,4,0), 5'b11111, 5'b11111, 5'b11111, pk(4,0,1,2,3), 5'b11111};
    tbl[6]  = '{5'b00000, pk(1,2,3,4,0), 5'b11111, 5'b11111, 5'b00000, SEL_IDLE,      5'b00000};
    tbl[7]  = '{5'b00101, pk(4,0,6,0,0), 5'b11111, 5'b11111, 5'b00000, SEL_IDLE,      5'b00000};
    tbl[8]  = '{5'b00101, pk(4,0,6,0,0), 5'b11111, 5'b11111, 5'b00001, pk(5,5,5,5,0), 5'b10000};
    tbl[9]  = '{5'b00100, pk(4,0,6,0,0), 5'b11111, 5'b11111, 5'b00000, SEL_IDLE,      5'b00000};
    tbl[10] = '{5'b00100, pk(4,0,6,0,0), 5'b11111, 5'b11111, 5'b00000, SEL_IDLE,      5'b00000};

    rst = 1'b1;
    drive('0, '0, '0, '1);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_select", 32'(select), 32'(SEL_IDLE));
    chk("reset_busy", 32'(out_busy), 32'h0);
    rst = 1'b0;

    // directed table: single packet, parallel switching, illegal destination
    for (int r = 0; r < 11; r++) begin
      drive(tbl[r].valid, tbl[r].dest, tbl[r].tail, tbl[r].ready);
      step();
      chk($sformatf("tbl%0d_grant", r), 32'(g_s), 32'(tbl[r].g));
      chk($sformatf("tbl%0d_select", r), 32'(sel_s), 32'(tbl[r].sel));
      chk($sformatf("tbl%0d_busy", r), 32'(busy_s), 32'(tbl[r].busy));
    end

    // reset mid-packet, then re-arbitration must start from pointer 0
    reset_pulse();
    drive(5'b00001, pk(2,0,0,0,0), 5'b00000, 5'b11111);
    step();
    step();
    chk("midpkt_locked", 32'(busy_s[2]), 32'h1);
    drive(5'b01001, pk(2,0,0,2,0), 5'b00000, 5'b11111);
    reset_pulse();
    step();
    step();
    chk("rearb_grant", 32'(g_s), 32'h01);
    chk("rearb_select2", 32'(sel_s[2*SW +: SW]), 32'h0);

    // round-robin among single-flit packets to output 1
    reset_pulse();
    exp_q = '{5'b00001, 5'b00100, 5'b10000, 5'b00001};
    drive(5'b10101, pk(1,0,1,0,1), 5'b11111, 5'b11111);
    for (int c = 0; c < 8; c++) begin
      step();
      if (g_s != '0) got_q.push_back(g_s);
    end
    chk("rr_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      chk($sformatf("rr_order%0d", k), 32'(got_q[k]), 32'(exp_q[k]));
    end

    // backpressure on a 4-flit packet from input 3 to output 0, input 1 waiting
    reset_pulse();
    for (int c = 0; c < 10; c++) begin
      logic [N-1:0] v, t, r;
      v = (c == 0) ? 5'b01000 : (c >= 8) ? 5'b00010 : 5'b01010;
      t = (c == 0) ? 5'b00000 : (c == 7) ? 5'b01010 : 5'b00010;
      r = (c >= 2 && c <= 4) ? 5'b11110 : 5'b11111;
      drive(v, pk(0,0,0,0,0), t, r);
      step();
      if (c >= 2 && c <= 4) begin
        chk($sformatf("bp_nogrant_c%0d", c), 32'(g_s), 32'h0);
        chk($sformatf("bp_sel_c%0d", c), 32'(sel_s[0 +: SW]), 32'h3);
      end
      if (c == 8) chk("bp_idle_gap", 32'(g_s[1]), 32'h0);
      if (c == 9) chk("bp_next_owner", 32'(g_s[1]), 32'h1);
    end

    // random traffic; a locked owner keeps its destination until released
    reset_pulse();
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0]    v, t, r;
      logic [N*DW-1:0] d;
      bit held;
      d = req_dest;
      for (int i = 0; i < N; i++) begin
        held = 0;
        for (int o = 0; o < N; o++) if (m_lock[o] != 0 && m_owner[o] == i) held = 1;
        if (!held) d[i*DW +: DW] = 3'($urandom_range(0, 6));
        v[i] = ($urandom_range(0, 3) != 0);
        t[i] = ($urandom_range(0, 2) == 0);
        r[i] = ($urandom_range(0, 3) != 0);
      end
      drive(v, d, t, r);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
